// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// bubble insertion, flush and a saturating stall counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  input  logic [DATA_W-1:0] read_data_1_i,
  input  logic [DATA_W-1:0] read_data_2_i,
  input  logic [DATA_W-1:0] sign_ext_i,
  input  logic              use_rt_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic              BranchType_i,
  input  logic              Jump_i,
  input  logic              ALUSrc_i,
  input  logic [1:0]        RegDst_i,
  input  logic [1:0]        MemtoReg_i,
  input  logic [2:0]        ALUOp_i,
  input  logic              flush_i,
  output logic [31:0]       instr_o,
  output logic [DATA_W-1:0] pc_plus4_o,
  output logic [DATA_W-1:0] read_data_1_o,
  output logic [DATA_W-1:0] read_data_2_o,
  output logic [DATA_W-1:0] sign_ext_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              Branch_o,
  output logic              BranchType_o,
  output logic              Jump_o,
  output logic              ALUSrc_o,
  output logic [1:0]        RegDst_o,
  output logic [1:0]        MemtoReg_o,
  output logic [2:0]        ALUOp_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] se;
    logic              rw;
    logic              mr;
    logic              mw;
    logic              br;
    logic              bt;
    logic              jmp;
    logic              asrc;
    logic [1:0]        rdst;
    logic [1:0]        m2r;
    logic [2:0]        aluop;
    logic              valid;
  } ex_t;

  ex_t              ex_d, ex_q, id_w;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [4:0]       ld_rt;
  logic             src_hit;
  logic             hz;

  assign id_w = '{
    instr: instr_i,
    pc4:   pc_plus4_i,
    rd1:   read_data_1_i,
    rd2:   read_data_2_i,
    se:    sign_ext_i,
    rw:    RegWrite_i,
    mr:    MemRead_i,
    mw:    MemWrite_i,
    br:    Branch_i,
    bt:    BranchType_i,
    jmp:   Jump_i,
    asrc:  ALUSrc_i,
    rdst:  RegDst_i,
    m2r:   MemtoReg_i,
    aluop: ALUOp_i,
    valid: 1'b1
  };

  // A load in EX writes its rt; $0 is never a real destination.
  assign ld_rt   = ex_q.instr[20:16];
  assign src_hit = (instr_i[25:21] == ld_rt)
                 | (use_rt_i & (instr_i[20:16] == ld_rt));
  assign hz      = ex_q.valid & ex_q.mr & (ld_rt != 5'd0) & src_hit;
  assign stall_o = hz & ~flush_i;

  always_comb begin
    ex_d  = id_w;
    cnt_d = cnt_q;
    unique case (1'b1)
      flush_i: ex_d = '0;
      stall_o: begin
        ex_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign instr_o       = ex_q.instr;
  assign pc_plus4_o    = ex_q.pc4;
  assign read_data_1_o = ex_q.rd1;
  assign read_data_2_o = ex_q.rd2;
  assign sign_ext_o    = ex_q.se;
  assign RegWrite_o    = ex_q.rw;
  assign MemRead_o     = ex_q.mr;
  assign MemWrite_o    = ex_q.mw;
  assign Branch_o      = ex_q.br;
  assign BranchType_o  = ex_q.bt;
  assign Jump_o        = ex_q.jmp;
  assign ALUSrc_o      = ex_q.asrc;
  assign RegDst_o      = ex_q.rdst;
  assign MemtoReg_o    = ex_q.m2r;
  assign ALUOp_o       = ex_q.aluop;
  assign valid_o       = ex_q.valid;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table, reset and saturation
// sequences, then random traffic against a reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] se;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        bt;
    logic        jmp;
    logic        asrc;
    logic [1:0]  rdst;
    logic [1:0]  m2r;
    logic [2:0]  aluop;
    logic        valid;
  } ex_t;

  typedef struct {
    logic [31:0] instr;
    logic        use_rt;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    int          e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr, pc4, rd1, rd2, se;
  logic        use_rt, rw, mr, mw, br, bt, jmp, asrc, flush;
  logic [1:0]  rdst, m2r;
  logic [2:0]  aluop;

  logic [31:0] a_instr, a_pc4, a_rd1, a_rd2, a_se;
  logic        a_rw, a_mr, a_mw, a_br, a_bt, a_jmp, a_asrc;
  logic [1:0]  a_rdst, a_m2r;
  logic [2:0]  a_aluop;
  logic        a_valid, a_stall;
  logic [15:0] a_cnt;

  logic [31:0] b_instr, b_pc4, b_rd1, b_rd2, b_se;
  logic        b_rw, b_mr, b_mw, b_br, b_bt, b_jmp, b_asrc;
  logic [1:0]  b_rdst, b_m2r;
  logic [2:0]  b_aluop;
  logic        b_valid, b_stall;
  logic [1:0]  b_cnt;

  ex_t dut_a, dut_b, m;
  int  c16, c2;
  int  checks = 0;
  int  errors = 0;
  bit  pend_stall;

  assign dut_a = {a_instr, a_pc4, a_rd1, a_rd2, a_se,
                  a_rw, a_mr, a_mw, a_br, a_bt, a_jmp,
                  a_asrc, a_rdst, a_m2r, a_aluop, a_valid};
  assign dut_b = {b_instr, b_pc4, b_rd1, b_rd2, b_se,
                  b_rw, b_mr, b_mw, b_br, b_bt, b_jmp,
                  b_asrc, b_rdst, b_m2r, b_aluop, b_valid};

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_n(rst_n), .instr_i(instr),
    .pc_plus4_i(pc4), .read_data_1_i(rd1),
    .read_data_2_i(rd2), .sign_ext_i(se),
    .use_rt_i(use_rt), .RegWrite_i(rw), .MemRead_i(mr),
    .MemWrite_i(mw), .Branch_i(br), .BranchType_i(bt),
    .Jump_i(jmp), .ALUSrc_i(asrc), .RegDst_i(rdst),
    .MemtoReg_i(m2r), .ALUOp_i(aluop), .flush_i(flush),
    .instr_o(a_instr), .pc_plus4_o(a_pc4),
    .read_data_1_o(a_rd1), .read_data_2_o(a_rd2),
    .sign_ext_o(a_se), .RegWrite_o(a_rw),
    .MemRead_o(a_mr), .MemWrite_o(a_mw),
    .Branch_o(a_br), .BranchType_o(a_bt),
    .Jump_o(a_jmp), .ALUSrc_o(a_asrc),
    .RegDst_o(a_rdst), .MemtoReg_o(a_m2r),
    .ALUOp_o(a_aluop), .valid_o(a_valid),
    .stall_o(a_stall), .stall_cnt_o(a_cnt)
  );

  id_ex_stage #(.DATA_W(32), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_n(rst_n), .instr_i(instr),
    .pc_plus4_i(pc4), .read_data_1_i(rd1),
    .read_data_2_i(rd2), .sign_ext_i(se),
    .use_rt_i(use_rt), .RegWrite_i(rw), .MemRead_i(mr),
    .MemWrite_i(mw), .Branch_i(br), .BranchType_i(bt),
    .Jump_i(jmp), .ALUSrc_i(asrc), .RegDst_i(rdst),
    .MemtoReg_i(m2r), .ALUOp_i(aluop), .flush_i(flush),
    .instr_o(b_instr), .pc_plus4_o(b_pc4),
    .read_data_1_o(b_rd1), .read_data_2_o(b_rd2),
    .sign_ext_o(b_se), .RegWrite_o(b_rw),
    .MemRead_o(b_mr), .MemWrite_o(b_mw),
    .Branch_o(b_br), .BranchType_o(b_bt),
    .Jump_o(b_jmp), .ALUSrc_o(b_asrc),
    .RegDst_o(b_rdst), .MemtoReg_o(b_m2r),
    .ALUOp_o(b_aluop), .valid_o(b_valid),
    .stall_o(b_stall), .stall_cnt_o(b_cnt)
  );

  task automatic chk(string nm, logic [255:0] act,
                     logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rand_inputs();
    instr  = $urandom;
    pc4    = $urandom;
    rd1    = $urandom;
    rd2    = $urandom;
    se     = $urandom;
    use_rt = 1'($urandom);
    rw     = 1'($urandom);
    mr     = 1'($urandom);
    mw     = 1'($urandom);
    br     = 1'($urandom);
    bt     = 1'($urandom);
    jmp    = 1'($urandom);
    asrc   = 1'($urandom);
    rdst   = 2'($urandom);
    m2r    = 2'($urandom);
    aluop  = 3'($urandom);
    flush  = 1'b0;
  endtask

  // Load-use rule: EX holds a valid load writing a nonzero rt
  // that the ID instruction reads; a flush overrides it.
  function automatic bit model_stall();
    logic [4:0] dst;
    dst = m.instr[20:16];
    if (!m.valid || !m.mr || dst == 5'd0 || flush) return 0;
    if (instr[25:21] == dst) return 1;
    return use_rt && (instr[20:16] == dst);
  endfunction

  task automatic check_outs();
    chk("ex_bundle_a", 256'(dut_a), 256'(m));
    chk("ex_bundle_b", 256'(dut_b), 256'(m));
    chk("cnt16", 256'(a_cnt), 256'(c16));
    chk("cnt2", 256'(b_cnt), 256'(c2));
  endtask

  // Inputs are already applied; check stall, clock, check outputs.
  task automatic cycle();
    #1;
    pend_stall = model_stall();
    chk("stall_a", 256'(a_stall), 256'(pend_stall));
    chk("stall_b", 256'(b_stall), 256'(pend_stall));
    @(posedge clk);
    if (flush) m = '0;
    else if (pend_stall) begin
      m = '0;
      if (c16 < 65535) c16++;
      if (c2 < 3) c2++;
    end else begin
      m = {instr, pc4, rd1, rd2, se, rw, mr, mw, br, bt,
           jmp, asrc, rdst, m2r, aluop, 1'b1};
    end
    #1;
    check_outs();
  endtask

  task automatic apply(logic [31:0] ins, logic ur, logic r,
                       logic w, logic fl);
    rand_inputs();
    instr  = ins;
    use_rt = ur;
    mr     = r;
    mw     = w;
    rw     = r | (~w & ins[31:26] != 6'h2b);
    flush  = fl;
  endtask

  localparam logic [31:0] LW2   = 32'h8C220000;
  localparam logic [31:0] LW0   = 32'h8C200000;
  localparam logic [31:0] ADD42 = 32'h00452020;
  localparam logic [31:0] ADD00 = 32'h00002020;
  localparam logic [31:0] ADD78 = 32'h00E82020;
  localparam logic [31:0] ADD33 = 32'h00632020;
  localparam logic [31:0] ADD3  = 32'h00221820;
  localparam logic [31:0] SW2   = 32'hACC20004;
  localparam logic [31:0] ADDI2 = 32'h20C20004;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{ADD3,  1, 0, 0, 1, 0, 0, 1, 0};
    tbl[1]  = '{LW2,   0, 1, 0, 1, 0, 0, 1, 0};
    tbl[2]  = '{ADD42, 1, 0, 0, 1, 0, 1, 0, 1};
    tbl[3]  = '{ADD42, 1, 0, 0, 1, 0, 0, 1, 1};
    tbl[4]  = '{LW2,   0, 1, 0, 1, 0, 0, 1, 1};
    tbl[5]  = '{SW2,   1, 0, 1, 0, 0, 1, 0, 2};
    tbl[6]  = '{SW2,   1, 0, 1, 0, 0, 0, 1, 2};
    tbl[7]  = '{LW2,   0, 1, 0, 1, 0, 0, 1, 2};
    tbl[8]  = '{ADDI2, 0, 0, 0, 1, 0, 0, 1, 2};
    tbl[9]  = '{LW0,   0, 1, 0, 1, 0, 0, 1, 2};
    tbl[10] = '{ADD00, 1, 0, 0, 1, 0, 0, 1, 2};
    tbl[11] = '{LW2,   0, 1, 0, 1, 0, 0, 1, 2};
    tbl[12] = '{ADD78, 1, 0, 0, 1, 0, 0, 1, 2};
    tbl[13] = '{LW2,   0, 1, 0, 1, 0, 0, 1, 2};
    tbl[14] = '{ADD42, 1, 0, 0, 1, 1, 0, 0, 2};
    tbl[15] = '{ADD33, 1, 0, 0, 1, 0, 0, 1, 2};

    m   = '0;
    c16 = 0;
    c2  = 0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      flush = 1'($urandom);
      @(negedge clk);
      check_outs();
      chk("rst_stall", 256'(a_stall), 256'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].instr, tbl[i].use_rt, tbl[i].mr,
            tbl[i].mw, tbl[i].flush);
      if (i == 0) rw = tbl[i].rw;
      #1;
      chk($sformatf("tbl%0d_stall", i), 256'(a_stall),
          256'(tbl[i].e_stall));
      cycle();
      chk($sformatf("tbl%0d_valid", i), 256'(a_valid),
          256'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_cnt", i), 256'(a_cnt),
          256'(tbl[i].e_cnt));
      if (i == 0) begin
        chk("t1_instr", 256'(a_instr), 256'(32'h00221820));
        chk("t1_regwrite", 256'(a_rw), 256'(1));
      end
      if (tbl[i].e_stall)
        chk($sformatf("tbl%0d_bubble_rw", i), 256'(a_rw),
            256'(0));
    end

    // Reset asserted mid-stall
    apply(LW2, 0, 1, 0, 0);
    cycle();
    apply(ADD42, 1, 0, 0, 0);
    #1;
    chk("pre_rst_stall", 256'(a_stall), 256'(1));
    rst_n = 1'b0;
    #1;
    m   = '0;
    c16 = 0;
    c2  = 0;
    chk("midrst_stall", 256'(a_stall), 256'(0));
    check_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Saturation of the 2-bit counter: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      apply(LW2, 0, 1, 0, 0);
      cycle();
      apply(ADD42, 1, 0, 0, 0);
      cycle();
      chk($sformatf("sat%0d_cnt2", i), 256'(b_cnt),
          256'((i < 3) ? i + 1 : 3));
      chk($sformatf("sat%0d_cnt16", i), 256'(a_cnt),
          256'(i + 1));
      cycle();
    end

    // Random traffic with small register numbers to force hits
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      instr[25:21] = 5'($urandom_range(0, 3));
      instr[20:16] = 5'($urandom_range(0, 3));
      mr    = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1);
  end

endmodule
